// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic [13:0] UART_KBAUD_DEFAULT = 14'd10416;
    localparam int unsigned UART_DATA_BITS     = 8;
    localparam int unsigned UART_FRAME_BITS    = 10;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide circular FIFO with occupancy count; a push while full is ignored.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               w_data,
    output logic [7:0]               r_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign r_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end, serialiser FSM, TXE/TC/overrun flags.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter logic [13:0] KBAUD = UART_KBAUD_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_w_data,
    input  logic       in_valid,
    output logic       out_ready,
    output logic       out_signal,
    output logic       out_TXE,
    output logic       out_TC,
    input  logic       in_ORE_clear,
    output logic       out_Tx_ORE
);

    localparam int unsigned CW         = $clog2(DEPTH) + 1;
    localparam logic [13:0] KBAUD_LAST = KBAUD - 14'd1;
    localparam logic [2:0]  LAST_BIT   = 3'(UART_DATA_BITS - 1);

    tx_state_t     state, state_next;
    logic [13:0]   baud_cnt, cnt_next;
    logic [2:0]    bit_idx, idx_next;
    logic [7:0]    shift, shift_next;
    logic          tx, tx_next;
    logic          pop;
    logic          baud_done;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ore;
    logic          clr_prev;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (in_valid),
        .pop    (pop),
        .w_data (in_w_data),
        .r_data (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign baud_done  = (baud_cnt == KBAUD_LAST);
    assign out_ready  = (fifo_count != CW'(DEPTH));
    assign out_TXE    = (fifo_count == '0);
    assign out_TC     = (state == IDLE) && fifo_empty;
    assign out_signal = tx;
    assign out_Tx_ORE = ore;

    // tx_next is the line level for the state being entered, so the registered line
    // changes on the same edge as the state.
    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt + 14'd1;
        idx_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rdata;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_next = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        idx_next   = bit_idx + 3'd1;
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    cnt_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_rdata;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            ore      <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= cnt_next;
            bit_idx  <= idx_next;
            shift    <= shift_next;
            tx       <= tx_next;
            clr_prev <= in_ORE_clear;
            if (in_valid && fifo_full) begin
                ore <= 1'b1;
            end else if (in_ORE_clear && !clr_prev) begin
                ore <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed + randomized bench for uart_tx_buffered with a waveform-level frame model.
module tb_uart_tx_buffered;

    localparam logic [13:0] KB    = 14'd4;
    localparam int          BITC  = 4;
    localparam int          FRAME = 10 * BITC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_w_data;
    logic       in_valid;
    logic       out_ready;
    logic       out_signal;
    logic       out_TXE;
    logic       out_TC;
    logic       in_ORE_clear;
    logic       out_Tx_ORE;

    uart_tx_buffered #(.KBAUD(KB), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_w_data    (in_w_data),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .out_signal   (out_signal),
        .out_TXE      (out_TXE),
        .out_TC       (out_TC),
        .in_ORE_clear (in_ORE_clear),
        .out_Tx_ORE   (out_Tx_ORE)
    );

    always #5 clk = ~clk;

    // trace[i] is the line level after the i-th rising edge.
    logic trace[$];
    always @(posedge clk) begin
        #2;
        trace.push_back(out_signal);
    end

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int find_low(input int from);
        for (int i = from; i < trace.size(); i++) begin
            if (trace[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic logic level(input logic [7:0] b, input int i);
        int k;
        k = i / BITC;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Compares the trace against the ideal 8N1 waveform of each byte in exp_q.
    task automatic check_frames(input string tag, input int from_idx, input int first_start,
                                input bit contiguous);
        int   p;
        int   endp;
        logic ok;
        p    = (first_start >= 0) ? first_start : find_low(from_idx);
        endp = trace.size();
        foreach (exp_q[f]) begin
            ok = (p >= 0) && (p + FRAME <= trace.size());
            if (ok) begin
                for (int i = 0; i < FRAME; i++) begin
                    if (trace[p+i] !== level(exp_q[f], i)) ok = 1'b0;
                end
            end
            chk($sformatf("%s_frame%0d_%02h", tag, f, exp_q[f]), 32'(ok), 32'd1);
            if (p >= 0) begin
                endp = p + FRAME;
                p    = contiguous ? p + FRAME : find_low(p + FRAME);
            end else begin
                endp = trace.size();
            end
        end
        chk($sformatf("%s_quiet_after", tag), find_low(endp), -1);
    endtask

    task automatic send(input int gap_max);
        int t;
        int gap;
        foreach (tx_q[j]) begin
            t = 0;
            while (out_ready !== 1'b1 && t < 200) begin
                in_valid = 1'b0;
                steps(1);
                t++;
            end
            chk("send_ready_wait", 32'(t < 200), 32'd1);
            in_valid  = 1'b1;
            in_w_data = tx_q[j];
            steps(1);
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                steps(gap);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int t;
        t = 0;
        while (out_TC !== 1'b1 && t < bound) begin
            steps(1);
            t++;
        end
        chk({tag, "_idle_timeout"}, 32'(t < bound), 32'd1);
    endtask

    initial begin
        int s;
        int r0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_w_data    = '0;
        in_ORE_clear = 1'b0;
        steps(3);
        rst_n = 1'b1;

        // Reset / idle hold
        for (int i = 0; i < 100; i++) begin
            steps(1);
            chk("reset_idle", 32'({out_signal, out_TXE, out_TC, out_ready, out_Tx_ORE}), 32'b11110);
        end

        // Single byte A5 with exact latency and TC timing
        s = trace.size();
        in_valid = 1'b1; in_w_data = 8'hA5;
        steps(1);
        in_valid = 1'b0;
        chk("single_txe_after_N", 32'(out_TXE), 32'd0);
        chk("single_tc_after_N", 32'(out_TC), 32'd0);
        chk("single_line_after_N", 32'(out_signal), 32'd1);
        steps(1);
        chk("single_txe_after_N1", 32'(out_TXE), 32'd1);
        chk("single_tc_after_N1", 32'(out_TC), 32'd0);
        chk("single_start_low", 32'(out_signal), 32'd0);
        steps(39);
        chk("single_tc_before_end", 32'(out_TC), 32'd0);
        steps(1);
        chk("single_tc_rise", 32'(out_TC), 32'd1);
        exp_q = '{8'hA5};
        check_frames("single", s, s + 1, 1'b1);

        // Burst of five bytes, back-to-back frames
        steps(5);
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        s = trace.size();
        send(0);
        chk("burst_full_ready", 32'(out_ready), 32'd0);
        steps(36);
        chk("burst_ready_still_low", 32'(out_ready), 32'd0);
        steps(1);
        chk("burst_ready_rise_on_pop", 32'(out_ready), 32'd1);
        wait_idle("burst", 300);
        chk("burst_no_ore", 32'(out_Tx_ORE), 32'd0);
        exp_q = tx_q;
        check_frames("burst", s, s + 1, 1'b1);

        // Overrun: dropped byte, sticky flag, edge clear, set-wins
        steps(3);
        tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        s = trace.size();
        send(0);
        chk("ovr_full", 32'(out_ready), 32'd0);
        in_valid = 1'b1; in_w_data = 8'hFF;
        steps(1);
        in_valid = 1'b0;
        chk("ovr_set", 32'(out_Tx_ORE), 32'd1);
        steps(1);
        chk("ovr_sticky", 32'(out_Tx_ORE), 32'd1);
        in_ORE_clear = 1'b1;
        steps(1);
        chk("ovr_clear_edge", 32'(out_Tx_ORE), 32'd0);
        in_ORE_clear = 1'b0;
        steps(1);
        chk("ovr_still_full", 32'(out_ready), 32'd0);
        in_valid = 1'b1; in_w_data = 8'hFF; in_ORE_clear = 1'b1;
        steps(1);
        in_valid = 1'b0;
        chk("ovr_set_wins", 32'(out_Tx_ORE), 32'd1);
        steps(1);
        chk("ovr_level_no_clear", 32'(out_Tx_ORE), 32'd1);
        in_ORE_clear = 1'b0;
        steps(1);
        in_ORE_clear = 1'b1;
        steps(1);
        in_ORE_clear = 1'b0;
        chk("ovr_clear_again", 32'(out_Tx_ORE), 32'd0);
        wait_idle("ovr", 300);
        exp_q = tx_q;
        check_frames("ovr", s, s + 1, 1'b1);

        // Push in the same cycle STOP pops, with three bytes queued
        steps(3);
        tx_q = '{8'h20, 8'h21, 8'h22, 8'h23};
        s = trace.size();
        send(0);
        steps(37);
        chk("simul_ready_before", 32'(out_ready), 32'd1);
        in_valid = 1'b1; in_w_data = 8'h24;
        steps(1);
        chk("simul_ready_after", 32'(out_ready), 32'd1);
        chk("simul_txe", 32'(out_TXE), 32'd0);
        in_w_data = 8'h25;
        steps(1);
        in_valid = 1'b0;
        chk("simul_count_was_3", 32'(out_ready), 32'd0);
        wait_idle("simul", 400);
        exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        check_frames("simul", s, s + 1, 1'b1);

        // Reset during data bit 3 of 3C with another byte queued
        steps(3);
        in_valid = 1'b1; in_w_data = 8'h3C;
        steps(1);
        in_w_data = 8'h99;
        steps(1);
        in_valid = 1'b0;
        steps(17);
        chk("rst_mid_bit3", 32'(out_signal), 32'd1);
        rst_n = 1'b0;
        steps(1);
        r0 = trace.size() - 1;
        chk("rst_outputs", 32'({out_signal, out_TXE, out_TC, out_ready, out_Tx_ORE}), 32'b11110);
        steps(1);
        rst_n = 1'b1;
        steps(50);
        chk("rst_fifo_discarded", find_low(r0), -1);
        s = trace.size();
        in_valid = 1'b1; in_w_data = 8'h81;
        steps(1);
        in_valid = 1'b0;
        wait_idle("after_rst", 100);
        exp_q = '{8'h81};
        check_frames("after_rst", s, s + 1, 1'b1);

        // Randomized bytes with random gaps
        steps(3);
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
        s = trace.size();
        send(3);
        wait_idle("random", 600);
        chk("random_no_ore", 32'(out_Tx_ORE), 32'd0);
        exp_q = tx_q;
        check_frames("random", s, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes from the user-side valid/ready handshake into a small FIFO and serialises them as 8N1 frames, LSB first, on the TX line. It is the transmit-direction counterpart of the receive status path in the UART top level. It reports TXE (buffer empty), TC (line idle) and a sticky write-overrun flag, in the same style as RXNE/ORE on the receive side.

## Interface
- KBAUD, 14'd10416 — clock cycles per bit; legal range 2..16383.
- DEPTH, 4 — FIFO depth in bytes; power of two, 2..16.

- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_w_data  in  8  byte to transmit.
- in_valid  in  1  write request; a byte is accepted on any edge where in_valid && out_ready.
- out_ready  out  1  FIFO not full; combinational from the FIFO count.
- out_signal  out  1  serial TX line; idles high.
- out_TXE  out  1  FIFO empty.
- out_TC  out  1  FIFO empty and the shifter is idle (last stop bit finished).
- in_ORE_clear  in  1  the rising edge clears out_Tx_ORE.
- out_Tx_ORE  out  1  sticky flag; set when in_valid is high while the FIFO is full (that byte is dropped).

## Operation
- Reset state:
  - FIFO empty; FSM in IDLE.
  - out_signal=1, out_ready=1, out_TXE=1, out_TC=1, out_Tx_ORE=0.
  - Edge-detect register cleared to 0.
- FIFO: circular buffer with read and write pointers that wrap modulo DEPTH, plus a count register (log2(DEPTH)+1 bits).
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - A push while full is ignored and sets out_Tx_ORE. The pointer and count do not change.
- FSM states are IDLE, START, DATA, STOP. A 14-bit baud counter runs 0..KBAUD-1, and a 3-bit bit index runs 0..7.
  - IDLE: out_signal=1. If the FIFO is non-empty, pop into the shift register, clear the counter, and go to START.
  - START: out_signal=0 for KBAUD cycles, then go to DATA with index 0.
  - DATA: out_signal=shift[0]. Each bit is held for KBAUD cycles, then the register shifts right. After index 7 expires, go to STOP.
  - STOP: out_signal=1 for KBAUD cycles. On the last cycle:
    - FIFO non-empty: pop and go straight to START, with no idle gap.
    - FIFO empty: go to IDLE.
- out_signal is registered.
- out_TC=1 only in IDLE with the FIFO empty.
- out_TXE reflects the FIFO count only; it does not include the byte in the shifter.
- out_Tx_ORE:
  - Set and clear in the same cycle: set wins.
  - Cleared on a rising edge of in_ORE_clear, using a registered previous value.
- Reset asserted mid-frame aborts the frame. out_signal is 1 from the cycle after the reset edge, and FIFO contents are discarded.

## Timing
- Byte accepted at edge N into an empty, idle block:
  - Edge N+1: IDLE pops it. out_signal is low from edge N+1.
  - out_TXE goes 0 after edge N and back to 1 after edge N+1.
  - out_TC goes 0 after edge N.
- Frame length is exactly 10*KBAUD cycles: start, 8 data bits, stop.
- Back-to-back frames are continuous. The next start bit begins the edge after the previous stop bit's final cycle.
- out_TC rises on the edge that returns the FSM to IDLE, i.e. 10*KBAUD cycles after the start bit began.
- out_ready falls on the edge a push makes the FIFO full, and rises on the edge of the next pop.

## Structure
- Shared package uart_pkg:
  - typedef tx_state_t {IDLE, START, DATA, STOP}.
  - Constant UART_KBAUD_DEFAULT = 14'd10416.
  - Constants UART_DATA_BITS = 8 and UART_FRAME_BITS = 10.
- One sub-module, uart_byte_fifo (parameter DEPTH). It provides push/pop/full/empty/count and is reused later by the RX buffer.
- The FSM, baud counter, shifter and flags live in uart_tx_buffered.

## Test plan
- Reset then idle, KBAUD=4: out_signal=1, out_TXE=1, out_TC=1, out_ready=1, out_Tx_ORE=0 held for 100 cycles.
- Single byte 8'hA5, KBAUD=4: line shows 0,1,0,1,0,0,1,0,1,1 with each level held exactly 4 cycles, start bit low from edge N+1. out_TC rises 40 cycles after the start bit.
- Burst of 5 bytes 8'h01..8'h05 on consecutive cycles, DEPTH=4:
  - out_ready drops once the FIFO is full.
  - The driver waits for out_ready before each write, so out_Tx_ORE stays 0.
  - The five frames appear with no idle cycle between stop and start.
- Overrun: fill the FIFO, then hold in_valid for one more cycle with 8'hFF:
  - out_Tx_ORE=1 and 8'hFF is never transmitted.
  - A rising edge on in_ORE_clear clears the flag.
  - Clear pulsed in the same cycle as a new overrun leaves out_Tx_ORE=1.
- Simultaneous push and pop: FIFO at count 3; write in the cycle STOP pops. out_ready stays 1, the count stays 3, and byte order is preserved.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 8'h3C. out_signal=1 from the next cycle, out_TXE=1, and a later byte 8'h81 is sent as a clean frame.
